// File: rtl/psum_output_packer.sv
// Packs four per-kernel psum byte streams (optional ReLU) into 32-bit words, buffers them per lane
// and round-robins them onto one valid/ready write stream; word out 2 cycles after its last byte.

module psum_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_dat = mem[rd_ptr[AW-1:0]];
endmodule

module psum_output_packer #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int REG_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BIT_WIDTH-1:0]      i_psum_kn0,
  input  logic [BIT_WIDTH-1:0]      i_psum_kn1,
  input  logic [BIT_WIDTH-1:0]      i_psum_kn2,
  input  logic [BIT_WIDTH-1:0]      i_psum_kn3,
  input  logic                      i_psum_kn0_val,
  input  logic                      i_psum_kn1_val,
  input  logic                      i_psum_kn2_val,
  input  logic                      i_psum_kn3_val,
  input  logic [REG_WIDTH-1:0]      i_conf_ctrl,
  input  logic                      i_flush,
  input  logic                      i_clr_err,
  output logic [BIT_WIDTH*PACK-1:0] o_wdata,
  output logic [1:0]                o_wkn,
  output logic                      o_wval,
  input  logic                      i_wready,
  output logic [NUM_KERNEL-1:0]     o_ovf,
  output logic                      o_idle
);
  localparam int WW = BIT_WIDTH * PACK;
  localparam int CW = $clog2(PACK);

  logic [NUM_KERNEL-1:0][BIT_WIDTH-1:0] psum;
  logic [NUM_KERNEL-1:0]                psum_vld;
  logic                                 relu_en;
  logic                                 conf_unused;

  logic [NUM_KERNEL-1:0]                lane_push;
  logic [NUM_KERNEL-1:0]                lane_busy;
  logic [NUM_KERNEL-1:0][WW-1:0]        lane_word;
  logic [NUM_KERNEL-1:0]                fifo_full;
  logic [NUM_KERNEL-1:0]                fifo_empty;
  logic [NUM_KERNEL-1:0]                fifo_pop;
  logic [NUM_KERNEL-1:0][WW-1:0]        fifo_head;
  logic [NUM_KERNEL-1:0]                drop;

  logic [1:0]                           rr_ptr;
  logic [1:0]                           grant_idx;
  logic                                 grant_vld;
  logic                                 load;

  assign psum        = {i_psum_kn3, i_psum_kn2, i_psum_kn1, i_psum_kn0};
  assign psum_vld    = {i_psum_kn3_val, i_psum_kn2_val, i_psum_kn1_val, i_psum_kn0_val};
  assign relu_en     = i_conf_ctrl[0];
  assign conf_unused = ^i_conf_ctrl[REG_WIDTH-1:1];

  for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
    logic [CW-1:0]                     cnt;
    logic [PACK-2:0][BIT_WIDTH-1:0]    held;
    logic [BIT_WIDTH-1:0]              lane_byte;
    logic [PACK-1:0][BIT_WIDTH-1:0]    merged;
    logic [CW:0]                       fill;
    logic                              push_full;

    assign lane_byte = (relu_en && psum[k][BIT_WIDTH-1]) ? '0 : psum[k];

    // Word as it stands after this cycle's byte; unfilled byte slots read as zero for flush.
    always_comb begin
      merged = '0;
      for (int j = 0; j < PACK-1; j++) begin
        if (j < int'(cnt)) merged[j] = held[j];
      end
      if (psum_vld[k]) merged[cnt] = lane_byte;
    end

    assign fill         = {1'b0, cnt} + {{CW{1'b0}}, psum_vld[k]};
    assign push_full    = psum_vld[k] && (cnt == CW'(PACK-1));
    assign lane_push[k] = push_full || (i_flush && (fill != '0));
    assign lane_word[k] = merged;
    assign lane_busy[k] = (cnt != '0);
    assign drop[k]      = lane_push[k] && fifo_full[k];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt  <= '0;
        held <= '0;
      end else if (lane_push[k]) begin
        cnt <= '0;
      end else if (psum_vld[k]) begin
        held[cnt] <= lane_byte;
        cnt       <= cnt + CW'(1);
      end
    end

    psum_fifo #(.W(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (lane_push[k]),
      .wr_dat (lane_word[k]),
      .rd_en  (fifo_pop[k]),
      .rd_dat (fifo_head[k]),
      .full   (fifo_full[k]),
      .empty  (fifo_empty[k])
    );
  end

  always_comb begin
    logic [1:0] cand;
    cand      = rr_ptr;
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    for (int i = 0; i < NUM_KERNEL; i++) begin
      cand = rr_ptr + 2'(i);
      if (!grant_vld && !fifo_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign load     = grant_vld && (!o_wval || i_wready);
  assign fifo_pop = load ? (NUM_KERNEL'(1) << grant_idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_wdata <= '0;
      o_wkn   <= '0;
      o_wval  <= 1'b0;
      rr_ptr  <= '0;
    end else if (load) begin
      o_wdata <= fifo_head[grant_idx];
      o_wkn   <= grant_idx;
      o_wval  <= 1'b1;
      rr_ptr  <= grant_idx + 2'd1;
    end else if (i_wready) begin
      o_wval  <= 1'b0;
    end
  end

  // A drop in the same cycle as a clear must stay visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           o_ovf <= '0;
    else if (i_clr_err) o_ovf <= drop;
    else                o_ovf <= o_ovf | drop;
  end

  assign o_idle = !o_wval && (&fifo_empty) && !(|lane_busy);
endmodule

// File: tb/tb_psum_output_packer.sv
// Bench for psum_output_packer: vector table plus multi-cycle sequences, scoreboarded output stream.
module tb_psum_output_packer;
  logic            clk = 1'b0;
  logic            rst;
  logic [3:0][7:0] psum;
  logic [3:0]      vld;
  logic [31:0]     conf;
  logic            flush;
  logic            clr;
  logic            wready;
  logic [31:0]     o_wdata;
  logic [1:0]      o_wkn;
  logic            o_wval;
  logic [3:0]      o_ovf;
  logic            o_idle;

  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] sb_q[$];

  typedef struct {
    logic [1:0]  kn;
    logic        relu;
    logic [31:0] bytes;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  psum_output_packer dut (
    .clk            (clk),
    .rst            (rst),
    .i_psum_kn0     (psum[0]),
    .i_psum_kn1     (psum[1]),
    .i_psum_kn2     (psum[2]),
    .i_psum_kn3     (psum[3]),
    .i_psum_kn0_val (vld[0]),
    .i_psum_kn1_val (vld[1]),
    .i_psum_kn2_val (vld[2]),
    .i_psum_kn3_val (vld[3]),
    .i_conf_ctrl    (conf),
    .i_flush        (flush),
    .i_clr_err      (clr),
    .o_wdata        (o_wdata),
    .o_wkn          (o_wkn),
    .o_wval         (o_wval),
    .i_wready       (wready),
    .o_ovf          (o_ovf),
    .o_idle         (o_idle)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] b, input logic relu, input logic fl);
    @(posedge clk); #1;
    vld   = v;
    psum  = b;
    conf  = {31'd0, relu};
    flush = fl;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(4'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && o_idle) break;
    end
    check({name, "_drain"}, {63'd0, (sb_q.size() == 0 && o_idle === 1'b1)}, 64'd1);
  endtask

  // Scoreboard: every accepted word must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && o_wval && wready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got kn=%0d data=%h, expected no word", o_wkn, o_wdata);
      end else begin
        check("word", {30'd0, o_wkn, o_wdata}, {30'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] b;
    logic [31:0] w;
    logic [7:0]  bv;

    vecs[0] = '{kn: 2'd0, relu: 1'b0, bytes: 32'h04030201, exp: 32'h04030201};
    vecs[1] = '{kn: 2'd2, relu: 1'b1, bytes: 32'h10FF7F80, exp: 32'h10007F00};
    vecs[2] = '{kn: 2'd1, relu: 1'b0, bytes: 32'h7F00FF80, exp: 32'h7F00FF80};
    vecs[3] = '{kn: 2'd3, relu: 1'b1, bytes: 32'h7EC00181, exp: 32'h7E000100};
    vecs[4] = '{kn: 2'd1, relu: 1'b1, bytes: 32'h78563412, exp: 32'h78563412};
    vecs[5] = '{kn: 2'd0, relu: 1'b1, bytes: 32'hFFFFFFFF, exp: 32'h00000000};

    rst = 1'b0; psum = '0; vld = '0; conf = '0; flush = 1'b0; clr = 1'b0; wready = 1'b1;
    #23;
    check("rst_wval",  {63'd0, o_wval}, 64'd0);
    check("rst_wdata", {32'd0, o_wdata}, 64'd0);
    check("rst_wkn",   {62'd0, o_wkn}, 64'd0);
    check("rst_ovf",   {60'd0, o_ovf}, 64'd0);
    check("rst_idle",  {63'd0, o_idle}, 64'd1);
    @(negedge clk); rst = 1'b1;

    // All four lanes complete a word together; expect kn0..kn3 back to back, twice.
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) begin
        bv = 8'(16 * r + 4 * j);
        drive(4'hF, {bv + 8'd3, bv + 8'd2, bv + 8'd1, bv}, 1'b0, 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
        w = '0;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(16 * r + 4 * j + k);
        sb_q.push_back({2'(k), w});
      end
      idle_cycles(1);
      @(negedge clk);
      check("rr_pre_wval", {63'd0, o_wval}, 64'd0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("rr_wval", {63'd0, o_wval}, 64'd1);
        check("rr_order", {62'd0, o_wkn}, 64'(k));
      end
      wait_drain("rr");
    end

    // Latency and single-cycle valid for one word on kn0.
    for (int j = 0; j < 4; j++) drive(4'b0001, 32'(j + 1), 1'b0, 1'b0);
    sb_q.push_back({2'd0, 32'h04030201});
    @(negedge clk);
    check("lat_t0", {63'd0, o_wval}, 64'd0);
    idle_cycles(1);
    @(negedge clk);
    check("lat_t1", {63'd0, o_wval}, 64'd0);
    @(negedge clk);
    check("lat_t2", {63'd0, o_wval}, 64'd1);
    check("lat_data", {32'd0, o_wdata}, 64'h04030201);
    @(negedge clk);
    check("lat_t3", {63'd0, o_wval}, 64'd0);
    wait_drain("lat");

    // Vector table: one lane, four bytes each, ReLU per entry.
    foreach (vecs[i]) begin
      for (int j = 0; j < 4; j++) begin
        b = 32'(vecs[i].bytes[8*j +: 8]) << (8 * vecs[i].kn);
        drive(4'(1) << vecs[i].kn, b, vecs[i].relu, 1'b0);
      end
      sb_q.push_back({vecs[i].kn, vecs[i].exp});
      idle_cycles(1);
    end
    wait_drain("table");

    // Flush: partial word, empty flush, flush with completing byte, flush with non-completing byte.
    drive(4'b0010, 32'h0000AA00, 1'b0, 1'b0);
    drive(4'b0010, 32'h0000BB00, 1'b0, 1'b0);
    drive(4'b0000, 32'h0, 1'b0, 1'b1);
    sb_q.push_back({2'd1, 32'h0000BBAA});
    idle_cycles(1);
    wait_drain("flush_partial");
    drive(4'b0000, 32'h0, 1'b0, 1'b1);
    idle_cycles(6);
    check("flush_empty_idle", {63'd0, o_idle}, 64'd1);
    for (int j = 0; j < 3; j++) drive(4'b0001, 32'(j + 1), 1'b0, 1'b0);
    drive(4'b0001, 32'h4, 1'b0, 1'b1);
    sb_q.push_back({2'd0, 32'h04030201});
    idle_cycles(1);
    wait_drain("flush_full");
    drive(4'b0100, 32'h00110000, 1'b0, 1'b0);
    drive(4'b0100, 32'h00220000, 1'b0, 1'b1);
    sb_q.push_back({2'd2, 32'h00002211});
    idle_cycles(1);
    wait_drain("flush_same");

    // Backpressure and overflow on kn3: reg + 4 FIFO words kept, sixth dropped.
    @(posedge clk); #1 wready = 1'b0;
    for (int wi = 0; wi < 6; wi++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        bv = 8'(4 * wi + j + 1);
        w[8*j +: 8] = bv;
        drive(4'b1000, {bv, 24'd0}, 1'b0, 1'b0);
      end
      if (wi < 5) sb_q.push_back({2'd3, w});
    end
    idle_cycles(3);
    @(negedge clk);
    check("ovf_set", {60'd0, o_ovf}, 64'h8);
    check("ovf_hold_wval", {63'd0, o_wval}, 64'd1);
    check("ovf_hold_wkn", {62'd0, o_wkn}, 64'd3);
    check("ovf_hold_data", {32'd0, o_wdata}, 64'h04030201);
    @(posedge clk); #1 wready = 1'b1;
    wait_drain("ovf");
    check("ovf_sticky", {60'd0, o_ovf}, 64'h8);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    check("ovf_clr", {60'd0, o_ovf}, 64'd0);

    // Async reset while a word is held on the output.
    @(posedge clk); #1 wready = 1'b0;
    for (int j = 0; j < 4; j++) drive((j < 2) ? 4'b0101 : 4'b0001, 32'h00330000 | 32'(j + 1), 1'b0, 1'b0);
    idle_cycles(3);
    @(negedge clk);
    check("arst_pre_wval", {63'd0, o_wval}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_wval", {63'd0, o_wval}, 64'd0);
    check("arst_wdata", {32'd0, o_wdata}, 64'd0);
    check("arst_idle", {63'd0, o_idle}, 64'd1);
    sb_q.delete();
    @(negedge clk); rst = 1'b1;
    wready = 1'b1;
    for (int j = 0; j < 4; j++) drive(4'b0010, 32'(8'h11 * (j + 1)) << 8, 1'b0, 1'b0);
    sb_q.push_back({2'd1, 32'h44332211});
    idle_cycles(1);
    wait_drain("arst_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_output_packer.md
# psum_output_packer

Downstream of the convolution core's partial-sum accumulator. Takes the four per-kernel 8-bit output streams (each with its own valid), optionally applies ReLU, and packs four consecutive bytes of each kernel into one 32-bit word. Each kernel has a small word FIFO. A round-robin arbiter drains the FIFOs onto a single valid/ready write stream tagged with the kernel index, ready for the output DMA / BRAM writer.

## Interface
Parameters:
- BIT_WIDTH, 8, width of one psum byte.
- NUM_KERNEL, 4, number of kernel lanes (ports fixed at 4).
- PACK, 4, bytes per output word; word width WW = BIT_WIDTH*PACK = 32.
- FIFO_DEPTH, 4, words per lane FIFO (power of 2).
- REG_WIDTH, 32, config register width.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- i_psum_kn0..i_psum_kn3  in  BIT_WIDTH each  signed psum byte per kernel.
- i_psum_kn0_val..i_psum_kn3_val  in  1 each  byte valid; no backpressure upstream.
- i_conf_ctrl  in  REG_WIDTH  bit0 = ReLU enable; other bits ignored.
- i_flush  in  1  one-cycle pulse: push partial words zero-padded.
- i_clr_err  in  1  one-cycle pulse: clear o_ovf.
- o_wdata  out  WW  packed word.
- o_wkn  out  2  kernel index of o_wdata.
- o_wval  out  1  o_wdata/o_wkn valid.
- i_wready  in  1  consumer accepts when o_wval && i_wready.
- o_ovf  out  NUM_KERNEL  sticky per-lane overflow (word dropped).
- o_idle  out  1  no partial bytes, all FIFOs empty, output register empty.

## Operation
- ReLU: when i_conf_ctrl[0]=1, a byte with MSB=1 becomes 0 before packing. Otherwise it is passed unchanged. i_conf_ctrl is sampled per byte.
- Lane packer: 2-bit byte count plus 3 held bytes. The first byte goes to bits [7:0], the second to [15:8], and so on (little-endian).
- On the 4th valid byte, the word {byte3, held2, held1, held0} is written into the lane FIFO in the same cycle, and the count returns to 0.
- Flush: on i_flush, each lane with count>0 pushes its held bytes with the unfilled upper bytes set to 0, and its count resets to 0.
  - If a valid byte arrives in the same cycle as flush, the byte is packed first.
  - If that byte completes a word, only the full word is pushed (no empty extra word).
  - Lanes with count=0 push nothing.
- Overflow: if a lane FIFO is full when a word must be written, the word is dropped and o_ovf[k] is set. A FIFO read in the same cycle does not free space for that write (the full flag is evaluated at start of cycle).
- o_ovf[k] clears on i_clr_err. If a set and a clear happen in the same cycle, set wins.
- Arbiter: round-robin over non-empty FIFOs. The priority pointer resets to lane 0. After granting lane k, the highest priority moves to lane (k+1) mod 4.
- Output register: loads the granted FIFO head when it is empty or when the current word is being accepted (o_wval && i_wready). This allows back-to-back words at 1 word/cycle.
- o_wdata and o_wkn hold stable while o_wval=1 && i_wready=0.

## Timing
- Reset (rst=0, async): o_wval=0, o_wdata=0, o_wkn=0, o_ovf=0, o_idle=1. All counts, FIFO pointers and the RR pointer are 0. Reset mid-operation discards partial bytes and buffered words.
- Latency: a 4th byte sampled at edge t puts the word in the FIFO at t+1, and o_wval=1 at t+2 if the output register is free and the lane wins arbitration.
- Flush latency: the same, counted from the i_flush edge.
- Throughput: sustained 1 output word/cycle with i_wready=1. Maximum input rate is 4 bytes/cycle (all lanes) = 1 word/cycle aggregate, so there is no loss with i_wready held high.
- o_idle is registered-consistent: it goes high the cycle after the last word is accepted.

## Test plan
- Single lane, ReLU off: kn0 bytes 0x01,0x02,0x03,0x04 on consecutive cycles, i_wready=1 -> o_wdata=0x04030201, o_wkn=0, o_wval for exactly 1 cycle, 2 cycles after byte 4.
- ReLU on: kn2 bytes 0x80,0x7F,0xFF,0x10 -> o_wdata=0x10007F00, o_wkn=2.
- All 4 lanes stream 4 bytes simultaneously, i_wready=1 -> 4 words in order kn0,kn1,kn2,kn3 on consecutive cycles. Repeat -> same order (RR pointer back at 0).
- Flush: kn1 bytes 0xAA,0xBB then i_flush -> o_wdata=0x0000BBAA, o_wkn=1. Flush with no partial data -> no o_wval.
- Backpressure/overflow: i_wready=0, feed 6 words (24 bytes) to kn3 -> output register + 4 FIFO entries kept, 6th word dropped, o_ovf=4'b1000. Raise i_wready -> 5 words out in order, o_idle=1 after. i_clr_err -> o_ovf=0.
- Async reset asserted mid-stream with o_wval=1 -> o_wval=0 immediately (no clock edge needed). After release, the first 4 bytes produce a correct fresh word.
